ex_mem: RTL and testbench
=========================

EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register/data width.
REQ-002 SHALL have parameter ALUOP_W, default 8, meaning ALU opcode width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk input 1 (rising edge), then rst input 1 (async, active-high).
REQ-004 SHALL have the following ports, in order:
- stall input 6: per-stage stall vector; bit 3 = EX stage, bit 4 = MEM stage.
- flush input 1: squash the stage.
- ex_wd input 5: destination register address.
- ex_wreg input 1: register write enable.
- ex_wdata input DATA_W: EX result.
- ex_whilo input 1: HI/LO write enable.
- ex_hi input DATA_W: HI value.
- ex_lo input DATA_W: LO value.
- ex_aluop input ALUOP_W: opcode forwarded to MEM.
- ex_mem_addr input DATA_W: load/store address.
- ex_reg2 input DATA_W: store data.
- hilo_i input 2*DATA_W: multi-cycle accumulate temporary from EX.
- cnt_i input 2: multi-cycle step count from EX.
- mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2: outputs, registered copies of the matching ex_* inputs, same widths.
- mem_valid output 1: stage holds a real instruction.
- hilo_o output 2*DATA_W: temporary returned to EX.
- cnt_o output 2: step count returned to EX.

Function
REQ-005 SHALL register all outputs on rising clk; no combinational input-to-output path.
REQ-006 SHALL have a latency of 1 cycle from ex_* to mem_* when stall[3]=0.
REQ-007 SHALL load all ex_* fields into mem_* when stall[3]=0, set mem_valid=1, and set hilo_o=0 and cnt_o=0.
REQ-008 SHALL insert a bubble when stall[3]=1 and stall[4]=0: all mem_* fields 0 (aluop = NOP 0), mem_valid=0, hilo_o<=hilo_i, cnt_o<=cnt_i.
REQ-009 SHALL hold all mem_*, mem_valid, hilo_o and cnt_o unchanged when stall[3]=1 and stall[4]=1.
REQ-010 SHALL treat stall[3]=0 with stall[4]=1 as illegal; the block SHALL then behave as a hold (REQ-009), and the bench SHALL flag it.
REQ-011 SHALL clear all outputs to 0 (including hilo_o and cnt_o) on flush=1 at the clock edge, regardless of stall; flush SHALL have priority over stall.
REQ-012 SHALL let cnt_o wrap freely; the block SHALL NOT interpret or increment cnt.
REQ-013 SHALL update hilo_o/cnt_o over consecutive bubble cycles each cycle from hilo_i/cnt_i, so that EX accumulates across a 2-cycle MADD/MSUB.

Reset
REQ-014 SHALL force every output to 0 asynchronously while rst=1, including mem_valid=0 and mem_aluop=NOP.
REQ-015 SHALL abandon any in-progress multi-cycle sequence on reset mid-operation (cnt_o=0, hilo_o=0); the first post-reset edge SHALL obey REQ-007..011.

Configuration
REQ-016 SHALL, with EX_MEM_MADD_EN defined, implement the hilo_i/cnt_i -> hilo_o/cnt_o storage per REQ-007..013.
REQ-017 SHALL, without EX_MEM_MADD_EN, tie hilo_o and cnt_o to constant 0 with no flops, while keeping the ports present.

Structure
REQ-018 SHALL take from the shared package: ZEROWORD, the NOP aluop (8'h00), the stall bit indices (STALL_EX=3, STALL_MEM=4), and the register-address width (5).
REQ-019 SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-020 SHALL cover pass-through: ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h1234_5678, stall=0 -> next cycle mem_wd=3, mem_wdata=32'h12345678, mem_valid=1.
REQ-021 SHALL cover bubble: stall=6'b001111, hilo_i=64'hA, cnt_i=2'd1 -> mem_wreg=0, mem_aluop=0, mem_valid=0, hilo_o=64'hA, cnt_o=1.
REQ-022 SHALL cover hold: load 32'hDEAD_BEEF, then stall=6'b011111 for 3 cycles -> mem_wdata stays 32'hDEADBEEF throughout.
REQ-023 SHALL cover flush priority: flush=1 with stall=6'b001111, cnt_i=1 -> all outputs 0, cnt_o=0.
REQ-024 SHALL cover async reset: assert rst mid-cycle between edges while mem_valid=1 -> outputs 0 immediately, before the next clk.
REQ-025 SHALL cover config off: build without EX_MEM_MADD_EN, drive hilo_i=64'hFFFF, cnt_i=3 under bubble -> hilo_o=0, cnt_o=0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared constants for the EX/MEM pipeline register: reset word, NOP opcode,
// stall-vector bit positions and the per-edge stage action decode.
package ex_mem_pkg;

   localparam logic [31:0] ZEROWORD   = 32'h0000_0000;
   localparam logic [7:0]  ALUOP_NOP  = 8'h00;
   localparam int          STALL_W    = 6;
   localparam int          STALL_EX   = 3;
   localparam int          STALL_MEM  = 4;
   localparam int          REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      ACT_LOAD   = 2'd0,
      ACT_BUBBLE = 2'd1,
      ACT_HOLD   = 2'd2,
      ACT_FLUSH  = 2'd3
   } stage_act_e;

   // EX stalled while MEM runs on: hand MEM a bubble. MEM stalled: hold,
   // which also absorbs the illegal "MEM stalled, EX running" case.
   function automatic stage_act_e stage_action(input logic flush,
                                                input logic stall_ex,
                                                input logic stall_mem);
      if (flush)                   return ACT_FLUSH;
      if (!stall_ex && !stall_mem) return ACT_LOAD;
      if (stall_ex && !stall_mem)  return ACT_BUBBLE;
      return ACT_HOLD;
   endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with flush, bubble and hold handling.
// Build macro EX_MEM_MADD_EN enables the hilo/cnt multi-cycle return storage.
module ex_mem
   import ex_mem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [STALL_W-1:0]    stall,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] ex_wd,
   input  logic                  ex_wreg,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic                  ex_whilo,
   input  logic [DATA_W-1:0]     ex_hi,
   input  logic [DATA_W-1:0]     ex_lo,
   input  logic [ALUOP_W-1:0]    ex_aluop,
   input  logic [DATA_W-1:0]     ex_mem_addr,
   input  logic [DATA_W-1:0]     ex_reg2,
   input  logic [2*DATA_W-1:0]   hilo_i,
   input  logic [1:0]            cnt_i,
   output logic [REG_ADDR_W-1:0] mem_wd,
   output logic                  mem_wreg,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_whilo,
   output logic [DATA_W-1:0]     mem_hi,
   output logic [DATA_W-1:0]     mem_lo,
   output logic [ALUOP_W-1:0]    mem_aluop,
   output logic [DATA_W-1:0]     mem_mem_addr,
   output logic [DATA_W-1:0]     mem_reg2,
   output logic                  mem_valid,
   output logic [2*DATA_W-1:0]   hilo_o,
   output logic [1:0]            cnt_o
);

   localparam logic [DATA_W-1:0]  ZERO_D   = DATA_W'(ZEROWORD);
   localparam logic [ALUOP_W-1:0] NOP_OP   = ALUOP_W'(ALUOP_NOP);

   stage_act_e w_act;

   logic [REG_ADDR_W-1:0] r_wd;
   logic                  r_wreg;
   logic [DATA_W-1:0]     r_wdata;
   logic                  r_whilo;
   logic [DATA_W-1:0]     r_hi;
   logic [DATA_W-1:0]     r_lo;
   logic [ALUOP_W-1:0]    r_aluop;
   logic [DATA_W-1:0]     r_mem_addr;
   logic [DATA_W-1:0]     r_reg2;
   logic                  r_valid;

   logic w_unused_stall;
   assign w_unused_stall = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};

   assign w_act = stage_action(flush, stall[STALL_EX], stall[STALL_MEM]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wd       <= '0;
         r_wreg     <= 1'b0;
         r_wdata    <= ZERO_D;
         r_whilo    <= 1'b0;
         r_hi       <= ZERO_D;
         r_lo       <= ZERO_D;
         r_aluop    <= NOP_OP;
         r_mem_addr <= ZERO_D;
         r_reg2     <= ZERO_D;
         r_valid    <= 1'b0;
      end else begin
         case (w_act)
            ACT_LOAD: begin
               r_wd       <= ex_wd;
               r_wreg     <= ex_wreg;
               r_wdata    <= ex_wdata;
               r_whilo    <= ex_whilo;
               r_hi       <= ex_hi;
               r_lo       <= ex_lo;
               r_aluop    <= ex_aluop;
               r_mem_addr <= ex_mem_addr;
               r_reg2     <= ex_reg2;
               r_valid    <= 1'b1;
            end
            ACT_HOLD: begin
            end
            default: begin
               r_wd       <= '0;
               r_wreg     <= 1'b0;
               r_wdata    <= ZERO_D;
               r_whilo    <= 1'b0;
               r_hi       <= ZERO_D;
               r_lo       <= ZERO_D;
               r_aluop    <= NOP_OP;
               r_mem_addr <= ZERO_D;
               r_reg2     <= ZERO_D;
               r_valid    <= 1'b0;
            end
         endcase
      end
   end

   assign mem_wd       = r_wd;
   assign mem_wreg     = r_wreg;
   assign mem_wdata    = r_wdata;
   assign mem_whilo    = r_whilo;
   assign mem_hi       = r_hi;
   assign mem_lo       = r_lo;
   assign mem_aluop    = r_aluop;
   assign mem_mem_addr = r_mem_addr;
   assign mem_reg2     = r_reg2;
   assign mem_valid    = r_valid;

`ifdef EX_MEM_MADD_EN
   logic [2*DATA_W-1:0] r_hilo;
   logic [1:0]          r_cnt;

   // Bubbles carry the EX accumulator back so a MADD/MSUB spans stall cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hilo <= '0;
         r_cnt  <= 2'd0;
      end else begin
         case (w_act)
            ACT_BUBBLE: begin
               r_hilo <= hilo_i;
               r_cnt  <= cnt_i;
            end
            ACT_HOLD: begin
            end
            default: begin
               r_hilo <= '0;
               r_cnt  <= 2'd0;
            end
         endcase
      end
   end

   assign hilo_o = r_hilo;
   assign cnt_o  = r_cnt;
`else
   logic w_unused_madd;
   assign w_unused_madd = ^{hilo_i, cnt_i};

   assign hilo_o = '0;
   assign cnt_o  = 2'd0;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Randomized bench for ex_mem against a stage-rule reference model;
// honours EX_MEM_MADD_EN when choosing the expected hilo_o/cnt_o.
module tb_ex_mem;

   localparam int DW = 32;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    stall;
   logic          flush;
   logic [4:0]    ex_wd;
   logic          ex_wreg;
   logic [DW-1:0] ex_wdata;
   logic          ex_whilo;
   logic [DW-1:0] ex_hi;
   logic [DW-1:0] ex_lo;
   logic [AW-1:0] ex_aluop;
   logic [DW-1:0] ex_mem_addr;
   logic [DW-1:0] ex_reg2;
   logic [2*DW-1:0] hilo_i;
   logic [1:0]    cnt_i;

   logic [4:0]    mem_wd;
   logic          mem_wreg;
   logic [DW-1:0] mem_wdata;
   logic          mem_whilo;
   logic [DW-1:0] mem_hi;
   logic [DW-1:0] mem_lo;
   logic [AW-1:0] mem_aluop;
   logic [DW-1:0] mem_mem_addr;
   logic [DW-1:0] mem_reg2;
   logic          mem_valid;
   logic [2*DW-1:0] hilo_o;
   logic [1:0]    cnt_o;

   always #5 clk = ~clk;

   ex_mem #(.DATA_W(DW), .ALUOP_W(AW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
      .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
      .hilo_i(hilo_i), .cnt_i(cnt_i),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
      .mem_valid(mem_valid), .hilo_o(hilo_o), .cnt_o(cnt_o)
   );

   typedef struct packed {
      logic [4:0]      wd;
      logic            wreg;
      logic [DW-1:0]   wdata;
      logic            whilo;
      logic [DW-1:0]   hi;
      logic [DW-1:0]   lo;
      logic [AW-1:0]   aluop;
      logic [DW-1:0]   addr;
      logic [DW-1:0]   reg2;
      logic            valid;
      logic [2*DW-1:0] hilo;
      logic [1:0]      cnt;
   } exp_t;

   exp_t m;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_illegal = 0;

`ifdef EX_MEM_MADD_EN
   localparam bit MADD = 1'b1;
`else
   localparam bit MADD = 1'b0;
`endif

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".wd"},    128'(mem_wd),       128'(m.wd));
      chk({tag, ".wreg"},  128'(mem_wreg),     128'(m.wreg));
      chk({tag, ".wdata"}, 128'(mem_wdata),    128'(m.wdata));
      chk({tag, ".whilo"}, 128'(mem_whilo),    128'(m.whilo));
      chk({tag, ".hi"},    128'(mem_hi),       128'(m.hi));
      chk({tag, ".lo"},    128'(mem_lo),       128'(m.lo));
      chk({tag, ".aluop"}, 128'(mem_aluop),    128'(m.aluop));
      chk({tag, ".addr"},  128'(mem_mem_addr), 128'(m.addr));
      chk({tag, ".reg2"},  128'(mem_reg2),     128'(m.reg2));
      chk({tag, ".valid"}, 128'(mem_valid),    128'(m.valid));
      chk({tag, ".hilo"},  128'(hilo_o),       128'(m.hilo));
      chk({tag, ".cnt"},   128'(cnt_o),        128'(m.cnt));
   endtask

   // Reference: what the stage should hold after an edge, from the stall/flush rules.
   task automatic model_edge();
      if (rst || flush) begin
         m = '0;
      end else if (!stall[3] && !stall[4]) begin
         m = '0;
         m.wd = ex_wd;       m.wreg = ex_wreg;   m.wdata = ex_wdata;
         m.whilo = ex_whilo; m.hi = ex_hi;       m.lo = ex_lo;
         m.aluop = ex_aluop; m.addr = ex_mem_addr; m.reg2 = ex_reg2;
         m.valid = 1'b1;
      end else if (stall[3] && !stall[4]) begin
         m = '0;
         if (MADD) begin
            m.hilo = hilo_i;
            m.cnt  = cnt_i;
         end
      end else if (!stall[3]) begin
         n_illegal++;
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk_all(tag);
   endtask

   task automatic rand_ex();
      ex_wd       = 5'($urandom);
      ex_wreg     = 1'($urandom);
      ex_wdata    = $urandom;
      ex_whilo    = 1'($urandom);
      ex_hi       = $urandom;
      ex_lo       = $urandom;
      ex_aluop    = 8'($urandom);
      ex_mem_addr = $urandom;
      ex_reg2     = $urandom;
      hilo_i      = {$urandom, $urandom};
      cnt_i       = 2'($urandom);
   endtask

   task automatic clear_ex();
      ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_whilo = 1'b0;
      ex_hi = '0; ex_lo = '0; ex_aluop = '0; ex_mem_addr = '0;
      ex_reg2 = '0; hilo_i = '0; cnt_i = 2'd0;
   endtask

   initial begin
      int sel;
      rst = 1'b1; stall = 6'd0; flush = 1'b0;
      clear_ex();
      m = '0;
      #3;
      chk_all("reset");
      tick("reset_edge");
      rst = 1'b0;

      // pass-through
      ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678; ex_aluop = 8'h21;
      tick("pass");
      chk("pass.wd_const",    128'(mem_wd),    128'(5'd3));
      chk("pass.wdata_const", 128'(mem_wdata), 128'(32'h1234_5678));
      chk("pass.valid_const", 128'(mem_valid), 128'(1'b1));

      // bubble
      stall = 6'b001111; hilo_i = 64'hA; cnt_i = 2'd1;
      tick("bubble");
      chk("bubble.wreg_const",  128'(mem_wreg),  128'(1'b0));
      chk("bubble.aluop_const", 128'(mem_aluop), 128'(8'h00));
      chk("bubble.valid_const", 128'(mem_valid), 128'(1'b0));
      chk("bubble.hilo_const",  128'(hilo_o),    MADD ? 128'(64'hA) : 128'(0));
      chk("bubble.cnt_const",   128'(cnt_o),     MADD ? 128'(2'd1) : 128'(0));

      // consecutive bubble: accumulator refreshed from EX each cycle
      hilo_i = 64'h1_0000_0002; cnt_i = 2'd2;
      tick("bubble2");
      chk("bubble2.cnt_const", 128'(cnt_o), MADD ? 128'(2'd2) : 128'(0));

      // hold
      stall = 6'b000000; ex_wdata = 32'hDEAD_BEEF; ex_wreg = 1'b1;
      tick("hold_load");
      stall = 6'b011111;
      for (int i = 0; i < 3; i++) begin
         ex_wdata = $urandom;
         hilo_i = {$urandom, $urandom};
         cnt_i = 2'($urandom);
         tick("hold");
         chk("hold.wdata_const", 128'(mem_wdata), 128'(32'hDEAD_BEEF));
      end

      // flush wins over stall, including a live accumulator
      stall = 6'b001111; cnt_i = 2'd3; hilo_i = 64'h55;
      tick("pre_flush");
      flush = 1'b1; cnt_i = 2'd1;
      tick("flush");
      chk("flush.cnt_const",   128'(cnt_o),     128'(0));
      chk("flush.valid_const", 128'(mem_valid), 128'(0));
      chk("flush.hilo_const",  128'(hilo_o),    128'(0));
      flush = 1'b0;

      // async reset between edges while valid
      stall = 6'b000000; rand_ex();
      tick("pre_rst");
      chk("pre_rst.valid_const", 128'(mem_valid), 128'(1'b1));
      #2 rst = 1'b1;
      #1;
      m = '0;
      chk_all("async_rst");
      chk("async_rst.valid_const", 128'(mem_valid), 128'(0));
      tick("rst_held");
      rst = 1'b0;

      // wrap-around count and accumulator width under bubble
      clear_ex();
      stall = 6'b001111; hilo_i = 64'hFFFF; cnt_i = 2'd3;
      tick("cfg");
      chk("cfg.hilo_const", 128'(hilo_o), MADD ? 128'(64'hFFFF) : 128'(0));
      chk("cfg.cnt_const",  128'(cnt_o),  MADD ? 128'(2'd3) : 128'(0));

      // illegal: MEM stalled while EX runs, expected to behave as hold
      stall = 6'b010000; rand_ex();
      tick("illegal");

      for (int c = 0; c < 600; c++) begin
         rand_ex();
         sel = int'($urandom_range(0, 9));
         stall = 6'($urandom) & 6'b100111;
         if (sel >= 5 && sel <= 7) stall[3] = 1'b1;
         else if (sel == 8) stall[4:3] = 2'b11;
         else if (sel == 9) stall[4] = 1'b1;
         flush = ($urandom_range(0, 99) < 8);
         tick("rnd");
         if ($urandom_range(0, 99) < 3) begin
            #2 rst = 1'b1;
            #1;
            m = '0;
            chk_all("rnd_rst");
            tick("rnd_rst_held");
            rst = 1'b0;
         end
      end

      $display("note: %0d cycles applied with stall[4] set and stall[3] clear (illegal, treated as hold)", n_illegal);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
